fifo_wr_arb: RTL

Round-robin write-port arbiter that shares the single write port of `my_async_fifo` among N producers in the write clock domain. It grants one producer at a time for a bounded burst and drives `w_en`/`w_data` directly into the FIFO. It also honours `full`, so no beat is ever lost or duplicated. It sits between the producer blocks and the FIFO write side, clocked by the FIFO write clock.

---
 rtl/fifo_wr_arb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port among N producers with bounded bursts.
// Optional macro FIFO_WR_ARB_TAG_EN adds the w_src tag output for a parallel tag FIFO.
module fifo_wr_arb #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N-1:0]      req,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      gnt,
  input  logic              full,
  output logic              w_en,
  output logic [DW-1:0]     w_data,
  output logic              busy,
  output logic [IDW-1:0]    owner
`ifdef FIFO_WR_ARB_TAG_EN
  ,
  output logic [IDW-1:0]    w_src
`endif
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] owner_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [IDW-1:0] pick, cand;
  logic           any_req;
  logic           own_req;

  // Wraps at N rather than 2^IDW so non-power-of-two N stays in range.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    if (int'(idx) >= N - 1) return '0;
    return idx + 1'b1;
  endfunction

  function automatic int rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return (s >= N) ? s - N : s;
  endfunction

  // Descending scan so the candidate closest to rr_ptr is the last to overwrite pick.
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDW'(rr_idx(rr_ptr, k));
      if (req[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
    end
  end

  assign own_req = req[owner];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= IDLE;
      owner  <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = pick;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (!own_req) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = wrap_inc(owner);
        end else if (!full) begin
          if (cnt == CNT_LAST) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(owner);
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write path is purely combinational so full gates w_en in the same cycle.
  always_comb begin
    busy   = 1'b0;
    w_en   = 1'b0;
    w_data = '0;
    gnt    = '0;
    if (state == BURST) begin
      busy   = 1'b1;
      w_en   = own_req & ~full;
      w_data = req_data[int'(owner) * DW +: DW];
      if (w_en) gnt[owner] = 1'b1;
    end
  end

`ifdef FIFO_WR_ARB_TAG_EN
  always_comb begin
    w_src = w_en ? owner : '0;
  end
`endif

endmodule
